// File: rtl/reduce_and_arbiter.sv
// rtl/reduce_and_arbiter.sv - round-robin arbiter feeding one shared serial reduce-AND unit (option: REDUCE_AND_EARLY_EXIT_EN)
module reduce_and_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 12,
    parameter int UNIT_W  = 3,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      out_valid,
    output logic                      out_result,
    output logic [ID_W-1:0]           out_id,
    output logic                      busy
);

    localparam int NCHUNK = (DATA_W + UNIT_W - 1) / UNIT_W;
    localparam int PAD_W  = NCHUNK * UNIT_W;
    localparam int CI_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_grant;
    logic [PAD_W-1:0]   r_operand;
    logic               r_acc;
    logic [CI_W-1:0]    r_chunk_idx;
    logic [NUM_REQ-1:0] r_req_ack;
    logic               r_out_valid;
    logic               r_out_result;
    logic [ID_W-1:0]    r_out_id;

    logic               w_any;
    logic [ID_W-1:0]    w_pick;
    logic [PAD_W-1:0]   w_pick_padded;
    logic [UNIT_W-1:0]  w_chunk;
    logic               w_chunk_and;
    logic               w_acc_next;
    logic               w_last_chunk;
    logic               w_finish;

    // First requester at or after last+1, wrapping around the requester ring.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        return pick;
    endfunction

    assign w_any  = |req_valid;
    assign w_pick = rr_pick(req_valid, r_last_grant);

    // Winner's operand, with bits above DATA_W forced to 1 so padding never clears the result.
    always_comb begin
        w_pick_padded                = '1;
        w_pick_padded[DATA_W-1:0]    = req_data[int'(w_pick)*DATA_W +: DATA_W];
    end

    assign w_chunk      = r_operand[int'(r_chunk_idx)*UNIT_W +: UNIT_W];
    assign w_chunk_and  = &w_chunk;
    assign w_acc_next   = r_acc & w_chunk_and;
    assign w_last_chunk = (r_chunk_idx == CI_W'(NCHUNK - 1));

`ifdef REDUCE_AND_EARLY_EXIT_EN
    // A zero chunk already decides the result, so the remaining chunks are skipped.
    assign w_finish = w_last_chunk || !w_chunk_and;
`else
    assign w_finish = w_last_chunk;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_next = S_BUSY;
            S_BUSY:  if (w_finish) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Grant latch, serial accumulation and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_grant      <= '0;
            r_operand    <= '0;
            r_acc        <= 1'b1;
            r_chunk_idx  <= '0;
            r_req_ack    <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= 1'b0;
            r_out_id     <= '0;
        end else begin
            r_req_ack   <= '0;
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_pick;
                        r_operand   <= w_pick_padded;
                        r_req_ack   <= NUM_REQ'(1) << w_pick;
                        r_acc       <= 1'b1;
                        r_chunk_idx <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    if (w_finish) begin
                        r_out_valid  <= 1'b1;
                        r_out_result <= w_acc_next;
                        r_out_id     <= r_grant;
                    end else begin
                        r_chunk_idx <= r_chunk_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    // Pointer advances only on completion, so an aborted grant is retried fairly.
                    r_last_grant <= r_grant;
                end
                default: begin
                    r_acc <= 1'b1;
                end
            endcase
        end
    end

    assign req_ack    = r_req_ack;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_id     = r_out_id;
    assign busy       = (r_state == S_BUSY) || (r_state == S_DONE);

endmodule

// File: tb/tb_reduce_and_arbiter.sv
// tb/tb_reduce_and_arbiter.sv - randomized self-checking bench for reduce_and_arbiter
module tb_reduce_and_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 12;
    localparam int UW  = 3;
    localparam int NCH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_ack;
    logic          out_valid;
    logic          out_result;
    logic [1:0]    out_id;
    logic          busy;

    logic [1:0]    v7;
    logic [13:0]   d7;
    logic [1:0]    ack7;
    logic          ov7;
    logic          or7;
    logic [0:0]    oid7;
    logic          busy7;

    int checks = 0;
    int errors = 0;
    int model_last;

    always #5 clk = ~clk;

    reduce_and_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .UNIT_W(UW)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .out_valid(out_valid), .out_result(out_result),
        .out_id(out_id), .busy(busy)
    );

    reduce_and_arbiter #(.NUM_REQ(2), .DATA_W(7), .UNIT_W(3)) u_dut7 (
        .clk(clk), .rst(rst), .req_valid(v7), .req_data(d7),
        .req_ack(ack7), .out_valid(ov7), .out_result(or7),
        .out_id(oid7), .busy(busy7)
    );

    // Reference: result is the AND of the operand's DATA_W bits.
    function automatic logic model_res(input logic [31:0] data, input int dw);
        for (int b = 0; b < dw; b++) if (!data[b]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: edges from the ack cycle to the out_valid cycle.
    function automatic int model_lat(input logic [31:0] data, input int dw, input int uw);
        int nch;
        nch = (dw + uw - 1) / uw;
`ifdef REDUCE_AND_EARLY_EXIT_EN
        for (int k = 0; k < nch; k++) begin
            for (int b = 0; b < uw; b++) begin
                if ((k*uw + b) < dw && !data[k*uw + b]) return k + 1;
            end
        end
`endif
        return nch;
    endfunction

    // Reference: round-robin choice starting after the last completed grant.
    function automatic int model_pick(input logic [NR-1:0] mask, input int last);
        for (int k = 1; k <= NR; k++) if (mask[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic wait_ack(input int budget, output int lat, output logic [NR-1:0] ack);
        lat = -1;
        ack = '0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (req_ack != '0) begin lat = n; ack = req_ack; break; end
        end
    endtask

    task automatic wait_out(input int budget, output int lat, output logic res, output logic [1:0] id);
        lat = -1;
        res = 1'bx;
        id  = 2'bxx;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; res = out_result; id = out_id; break; end
        end
    endtask

    task automatic run_txn(input logic [NR-1:0] mask, input logic [NR*DW-1:0] data,
                           output logic [NR-1:0] ack, output int ack_lat, output int out_lat,
                           output logic res, output logic [1:0] id, output logic held);
        req_data  = data;
        req_valid = mask;
        wait_ack(20, ack_lat, ack);
        req_valid = '0;
        wait_out(20, out_lat, res, id);
        @(posedge clk); #1;
        held = !out_valid && (out_result === res) && (out_id === id);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        v7 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = NR - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; v7 = '0; d7 = '0;
        repeat (2) @(posedge clk); #1;
        checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b exp 0000", req_ack); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_result !== 1'b0 || out_id !== 2'd0) begin errors++; $display("FAIL reset_result got %b/%0d exp 0/0", out_result, out_id); end
        checks++; if (busy !== 1'b0 || busy7 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b exp 0/0", busy, busy7); end
        rst = 1'b0;
        model_last = NR - 1;
    endtask

    task automatic test_transaction(input logic [NR-1:0] mask, input logic [NR*DW-1:0] data, input string tag);
        int eg, al, ol;
        logic [NR-1:0] ack;
        logic res, held;
        logic [1:0] id;
        logic [31:0] opd;
        eg  = model_pick(mask, model_last);
        opd = 32'(data[eg*DW +: DW]);
        run_txn(mask, data, ack, al, ol, res, id, held);
        checks++; if (ack !== 4'(1 << eg)) begin errors++; $display("FAIL %s ack got %b exp %b", tag, ack, 4'(1 << eg)); end
        checks++; if (al != 1) begin errors++; $display("FAIL %s ack_latency got %0d exp 1", tag, al); end
        checks++; if (ol != model_lat(opd, DW, UW)) begin errors++; $display("FAIL %s out_latency got %0d exp %0d", tag, ol, model_lat(opd, DW, UW)); end
        checks++; if (res !== model_res(opd, DW)) begin errors++; $display("FAIL %s result got %b exp %b", tag, res, model_res(opd, DW)); end
        checks++; if (id !== 2'(eg)) begin errors++; $display("FAIL %s id got %0d exp %0d", tag, id, eg); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL %s pulse_hold got %b exp 1", tag, held); end
        model_last = eg;
    endtask

    task automatic test_random();
        logic [NR*DW-1:0] data;
        logic [NR-1:0] mask;
        for (int t = 0; t < 12; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 1) == 0) data[i*DW +: DW] = 12'hFFF;
                else data[i*DW +: DW] = 12'hFFF & ~(12'd1 << $urandom_range(0, DW - 1));
            end
            test_transaction(mask, data, "random");
        end
    endtask

    task automatic test_back_to_back();
        int ack_cyc[$];
        int ack_idx[$];
        int out_ids[$];
        logic out_res[$];
        int al;
        logic res;
        logic [1:0] id;
        do_reset();
        req_data  = {NR{12'hFFF}};
        req_valid = 4'hF;
        for (int n = 1; n <= 60 && ack_cyc.size() < 5; n++) begin
            @(posedge clk); #1;
            if (req_ack != '0) begin
                checks++; if (!$onehot(req_ack)) begin errors++; $display("FAIL b2b_onehot got %b exp one-hot", req_ack); end
                ack_cyc.push_back(n);
                for (int i = 0; i < NR; i++) if (req_ack[i]) ack_idx.push_back(i);
            end
            if (out_valid) begin out_ids.push_back(int'(out_id)); out_res.push_back(out_result); end
        end
        req_valid = '0;
        checks++; if (ack_cyc.size() != 5) begin errors++; $display("FAIL b2b_ack_count got %0d exp 5", ack_cyc.size()); end
        for (int i = 0; i < ack_idx.size(); i++) begin
            checks++; if (ack_idx[i] != (model_last + 1 + i) % NR) begin errors++; $display("FAIL b2b_ack_order[%0d] got %0d exp %0d", i, ack_idx[i], (model_last + 1 + i) % NR); end
            if (i > 0) begin
                checks++; if (ack_cyc[i] - ack_cyc[i-1] != NCH + 2) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d exp %0d", i, ack_cyc[i] - ack_cyc[i-1], NCH + 2); end
            end
        end
        checks++; if (out_ids.size() != 4) begin errors++; $display("FAIL b2b_out_count got %0d exp 4", out_ids.size()); end
        for (int i = 0; i < out_ids.size(); i++) begin
            checks++; if (out_ids[i] != i || out_res[i] !== 1'b1) begin errors++; $display("FAIL b2b_out[%0d] got id %0d res %b exp id %0d res 1", i, out_ids[i], out_res[i], i); end
        end
        wait_out(20, al, res, id);
        checks++; if (al < 0 || id !== 2'd0) begin errors++; $display("FAIL b2b_drain got lat %0d id %0d exp id 0", al, id); end
        @(posedge clk); #1;
        model_last = 0;
    endtask

    task automatic test_reset_mid();
        int al, seen;
        logic [NR-1:0] ack;
        logic res;
        logic [1:0] id;
        test_transaction(4'b0010, {NR{12'hFFF}}, "pre_abort");
        req_data  = {NR{12'hFFF}};
        req_valid = 4'b0100;
        wait_ack(20, al, ack);
        req_valid = '0;
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL abort_ack got %b exp 0100", ack); end
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ack !== 4'b0 || out_valid !== 1'b0 || out_result !== 1'b0 || out_id !== 2'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL abort_outputs got ack %b ov %b res %b id %0d busy %b exp all 0", req_ack, out_valid, out_result, out_id, busy); end
        rst = 1'b0;
        model_last = NR - 1;
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_out got %0d pulses exp 0", seen); end
        req_valid = 4'hF;
        wait_ack(20, al, ack);
        req_valid = '0;
        checks++; if (ack !== 4'(1 << model_pick(4'hF, model_last))) begin errors++; $display("FAIL abort_regrant got %b exp 0001", ack); end
        wait_out(20, al, res, id);
        checks++; if (id !== 2'd0 || res !== 1'b1) begin errors++; $display("FAIL abort_regrant_out got id %0d res %b exp 0/1", id, res); end
        @(posedge clk); #1;
        model_last = 0;
    endtask

    task automatic test_latched();
        int al, ol;
        logic [NR-1:0] ack;
        logic res;
        logic [1:0] id;
        req_data  = {NR{12'hFFF}};
        req_valid = 4'b0001;
        wait_ack(20, al, ack);
        req_valid = '0;
        @(posedge clk); #1;
        req_data[11:0] = 12'h000;
        wait_out(20, ol, res, id);
        checks++; if (res !== 1'b1 || id !== 2'(model_pick(4'b0001, model_last))) begin errors++; $display("FAIL latched_result got res %b id %0d exp 1/0", res, id); end
        checks++; if (ol + 1 != NCH) begin errors++; $display("FAIL latched_latency got %0d exp %0d", ol + 1, NCH); end
        @(posedge clk); #1;
        model_last = 0;
    endtask

    task automatic test_small_width();
        logic [6:0] vals [2];
        int al, ol;
        logic res;
        vals[0] = 7'h7F;
        vals[1] = 7'h3F;
        for (int t = 0; t < 2; t++) begin
            d7 = {7'h00, vals[t]};
            v7 = 2'b01;
            al = -1; ol = -1; res = 1'bx;
            for (int n = 1; n <= 20; n++) begin @(posedge clk); #1; if (ack7 != 2'b00) begin al = n; break; end end
            v7 = 2'b00;
            for (int n = 1; n <= 20; n++) begin @(posedge clk); #1; if (ov7) begin ol = n; res = or7; break; end end
            checks++; if (al != 1) begin errors++; $display("FAIL w7_ack[%0d] got %0d exp 1", t, al); end
            checks++; if (res !== model_res(32'(vals[t]), 7) || oid7 !== 1'b0) begin errors++; $display("FAIL w7_result[%0d] got %b id %0d exp %b id 0", t, res, oid7, model_res(32'(vals[t]), 7)); end
            checks++; if (ol != model_lat(32'(vals[t]), 7, 3)) begin errors++; $display("FAIL w7_latency[%0d] got %0d exp %0d", t, ol, model_lat(32'(vals[t]), 7, 3)); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_transaction(4'b0001, {36'h0, 12'hFFF}, "all_ones_req0");
        test_transaction(4'b0010, {24'h0, 12'hFF7, 12'h0}, "bit3_zero_req1");
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_latched();
        test_small_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
